// File: rtl/cam_umq.sv
// Direct-mapped unexpected-message queue: header-indexed store with a 3-state lookup engine.
// Optional rejected-insert counter enabled by defining CAM_UMQ_DROP_CNT_EN.
module cam_umq #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  msg_insert,
    input  logic [ADDR_WIDTH-1:0] msg_hdr,
    input  logic [DATA_WIDTH-1:0] msg_ptr,
    input  logic                  find,
    input  logic [ADDR_WIDTH-1:0] find_hdr,
    output logic                  busy,
    output logic                  found,
    output logic                  not_found,
    output logic [DATA_WIDTH-1:0] matched_ptr,
    output logic                  msg_drop,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  q_empty,
    output logic [15:0]           drop_count
);

    localparam int unsigned ENTRIES = 2 ** ADDR_WIDTH;
    localparam int unsigned CW      = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t                state_q;
    logic [ENTRIES-1:0]    valid_q;
    logic [DATA_WIDTH-1:0] mem [ENTRIES];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  found_q;
    logic                  not_found_q;
    logic                  msg_drop_q;
    logic [DATA_WIDTH-1:0] matched_ptr_q;

    logic ins_ok;
    logic retire;
    logic lookup_hit;

    assign ins_ok     = msg_insert && !valid_q[msg_hdr];
    assign retire     = (state_q == RESP);
    assign lookup_hit = find && (state_q == IDLE) && (count_q != '0) && valid_q[find_hdr];

    // Occupancy: an accepted insert and a retiring hit on one edge cancel out
    always_comb begin
        count_d = count_q;
        case ({ins_ok, retire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer RAM, no reset, registered read issued when a lookup hits
    always_ff @(posedge clk) begin
        if (ins_ok) begin
            mem[msg_hdr] <= msg_ptr;
        end
        if (lookup_hit) begin
            rd_data_q <= mem[find_hdr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            count_q       <= '0;
            addr_q        <= '0;
            found_q       <= 1'b0;
            not_found_q   <= 1'b0;
            msg_drop_q    <= 1'b0;
            matched_ptr_q <= '0;
        end else begin
            found_q       <= 1'b0;
            not_found_q   <= 1'b0;
            matched_ptr_q <= '0;
            msg_drop_q    <= msg_insert && !ins_ok;
            count_q       <= count_d;
            if (ins_ok) begin
                valid_q[msg_hdr] <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (lookup_hit) begin
                        addr_q  <= find_hdr;
                        state_q <= READ;
                    end else if (find) begin
                        not_found_q <= 1'b1;
                    end
                end
                READ: begin
                    found_q       <= 1'b1;
                    matched_ptr_q <= rd_data_q;
                    state_q       <= RESP;
                end
                RESP: begin
                    // Entry stays valid through RESP so inserts to it are still dropped
                    valid_q[addr_q] <= 1'b0;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CAM_UMQ_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (msg_drop_q && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    assign busy        = (state_q != IDLE);
    assign found       = found_q;
    assign not_found   = not_found_q;
    assign matched_ptr = matched_ptr_q;
    assign msg_drop    = msg_drop_q;
    assign count       = count_q;
    assign q_empty     = (count_q == '0);

endmodule

// File: tb/tb_cam_umq.sv
// Self-checking bench for cam_umq: directed scenarios plus randomized traffic vs a transaction model.
module tb_cam_umq;

    logic        clk;
    logic        rst_n;
    logic        msg_insert;
    logic [15:0] msg_hdr;
    logic [31:0] msg_ptr;
    logic        find;
    logic [15:0] find_hdr;
    logic        busy;
    logic        found;
    logic        not_found;
    logic [31:0] matched_ptr;
    logic        msg_drop;
    logic [16:0] count;
    logic        q_empty;
    logic [15:0] drop_count;

    cam_umq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .msg_insert  (msg_insert),
        .msg_hdr     (msg_hdr),
        .msg_ptr     (msg_ptr),
        .find        (find),
        .find_hdr    (find_hdr),
        .busy        (busy),
        .found       (found),
        .not_found   (not_found),
        .matched_ptr (matched_ptr),
        .msg_drop    (msg_drop),
        .count       (count),
        .q_empty     (q_empty),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: set of stored messages plus the single outstanding lookup
    bit          valid_m [65536];
    logic [31:0] ptr_m   [65536];
    int          cnt_m;
    bit          infl_m;
    int          infl_age;
    logic [15:0] infl_hdr;
    bit          e_found, e_nf, e_drop;
    logic [31:0] e_ptr;
    int          dc_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 65536; i++) valid_m[i] = 1'b0;
        cnt_m = 0; infl_m = 0; infl_age = 0; infl_hdr = '0;
        e_found = 0; e_nf = 0; e_drop = 0; e_ptr = '0; dc_m = 0;
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge
    task automatic model_edge(input bit ins, input logic [15:0] h, input logic [31:0] p,
                              input bit f, input logic [15:0] fh);
        bit accept;
        bit start;
        bit retire;
`ifdef CAM_UMQ_DROP_CNT_EN
        if (e_drop && dc_m < 65535) dc_m++;
`endif
        accept  = ins && !valid_m[h];
        e_drop  = ins && valid_m[h];
        e_found = 0; e_nf = 0; e_ptr = '0;
        start = 0; retire = 0;
        if (infl_m && infl_age == 0) begin
            e_found = 1; e_ptr = ptr_m[infl_hdr]; infl_age = 1;
        end else if (infl_m) begin
            retire = 1;
        end else if (f) begin
            if (valid_m[fh]) start = 1;
            else e_nf = 1;
        end
        if (retire) begin
            valid_m[infl_hdr] = 0; cnt_m--; infl_m = 0;
        end
        if (start) begin
            infl_m = 1; infl_age = 0; infl_hdr = fh;
        end
        if (accept) begin
            valid_m[h] = 1; ptr_m[h] = p; cnt_m++;
        end
    endtask

    task automatic check_all();
        chk("found", 32'(found), 32'(e_found));
        chk("not_found", 32'(not_found), 32'(e_nf));
        chk("matched_ptr", matched_ptr, e_ptr);
        chk("msg_drop", 32'(msg_drop), 32'(e_drop));
        chk("count", 32'(count), 32'(cnt_m));
        chk("q_empty", 32'(q_empty), 32'(cnt_m == 0));
        chk("busy", 32'(busy), 32'(infl_m));
        chk("drop_count", 32'(drop_count), 32'(dc_m));
    endtask

    task automatic cycle(input bit ins, input logic [15:0] h, input logic [31:0] p,
                         input bit f, input logic [15:0] fh);
        msg_insert = ins; msg_hdr = h; msg_ptr = p; find = f; find_hdr = fh;
        @(posedge clk);
        model_edge(ins, h, p, f, fh);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, 32'h0, 0, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0; msg_insert = 0; msg_hdr = '0; msg_ptr = '0; find = 0; find_hdr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single hit: 2-cycle latency, entry retired afterwards
        cycle(1, 16'h0102, 32'hDEAD0000, 0, 16'h0);
        chk("t1_count1", 32'(count), 32'd1);
        cycle(0, 16'h0, 32'h0, 1, 16'h0102);
        chk("t1_found_early", 32'(found), 32'd0);
        cycle(0, 16'h0, 32'h0, 0, 16'h0);
        chk("t1_found", 32'(found), 32'd1);
        chk("t1_ptr", matched_ptr, 32'hDEAD0000);
        cycle(0, 16'h0, 32'h0, 0, 16'h0);
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_empty", 32'(q_empty), 32'd1);

        // Miss on empty queue
        cycle(0, 16'h0, 32'h0, 1, 16'h0055);
        chk("t2_nf", 32'(not_found), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        idle(1);

        // Duplicate insert is dropped
        cycle(1, 16'h0010, 32'h11111111, 0, 16'h0);
        cycle(1, 16'h0010, 32'h22222222, 0, 16'h0);
        chk("t3_drop", 32'(msg_drop), 32'd1);
        chk("t3_count", 32'(count), 32'd1);
        idle(1);
`ifdef CAM_UMQ_DROP_CNT_EN
        chk("t3_dropcnt", 32'(drop_count), 32'd1);
`else
        chk("t3_dropcnt", 32'(drop_count), 32'd0);
`endif
        cycle(0, 16'h0, 32'h0, 1, 16'h0010);
        cycle(0, 16'h0, 32'h0, 0, 16'h0);
        chk("t3_ptr_kept", matched_ptr, 32'h11111111);
        idle(1);

        // Insert on the retire edge leaves count unchanged
        cycle(1, 16'h0001, 32'hA0000001, 0, 16'h0);
        cycle(1, 16'h0002, 32'hA0000002, 0, 16'h0);
        cycle(0, 16'h0, 32'h0, 1, 16'h0001);
        cycle(0, 16'h0, 32'h0, 0, 16'h0);
        chk("t4_found", 32'(found), 32'd1);
        cycle(1, 16'h0003, 32'hA0000003, 0, 16'h0);
        chk("t4_count", 32'(count), 32'd2);

        // Find while busy is ignored
        cycle(1, 16'h0001, 32'hB0000001, 0, 16'h0);
        cycle(0, 16'h0, 32'h0, 1, 16'h0001);
        cycle(0, 16'h0, 32'h0, 1, 16'h0002);
        chk("t5_ptr", matched_ptr, 32'hB0000001);
        idle(3);
        chk("t5_count", 32'(count), 32'd2);

        // Reset during READ aborts the lookup and empties the queue
        cycle(0, 16'h0, 32'h0, 1, 16'h0002);
        find = 0;
        chk("t6_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        cycle(0, 16'h0, 32'h0, 1, 16'h0002);
        chk("t6_nf", 32'(not_found), 32'd1);
        idle(1);

        // Randomized traffic on a small header set to force collisions and busy finds
        for (int i = 0; i < 400; i++) begin
            logic [15:0] h;
            logic [15:0] fh;
            h  = 16'h0200 | 16'($urandom_range(0, 7));
            fh = 16'h0200 | 16'($urandom_range(0, 7));
            cycle(($urandom_range(0, 99) < 45), h, $urandom, ($urandom_range(0, 99) < 40), fh);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
